ex_operand_stage: RTL and testbench
===================================

# ex_operand_stage

ID/EX pipeline stage directly upstream of the `alu`. It registers one decoded instruction per cycle and resolves forwarding from EX/MEM and MEM/WB. It builds the ALU operands `a`, `b` and `alu_control`, and carries the memory/writeback control bits to EX. It also detects load-use hazards and inserts a bubble on its own.

## Interface
Parameters:
- `WIDTH`, 32, datapath width.
- `RA`, 5, register-address width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `id_valid`  in  1  decode holds a valid instruction.
- `id_rs_data`, `id_rt_data`  in  WIDTH  register-file read data.
- `id_imm`  in  WIDTH  immediate, already sign/zero-extended by decode.
- `id_shamt`  in  5  shift amount.
- `id_rs`, `id_rt`, `id_rd`  in  RA  source registers and final destination register.
- `id_alu_control`  in  6  ALU function code.
- `id_alu_src`  in  1  0 selects rt as `b`, 1 selects the immediate.
- `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_mem_to_reg`  in  1 each  control bits.
- `stall`  in  1  downstream stall: hold all registered state.
- `flush`  in  1  squash: load a bubble.
- `exmem_reg_write`  in  1, `exmem_rd`  in  RA, `exmem_result`  in  WIDTH  EX/MEM forward source.
- `memwb_reg_write`  in  1, `memwb_rd`  in  RA, `memwb_result`  in  WIDTH  MEM/WB forward source.
- `ex_valid`  out  1  registered instruction is valid.
- `ex_a`, `ex_b`  out  WIDTH  ALU operands.
- `ex_alu_control`  out  6  to `alu.alu_control`.
- `ex_store_data`  out  WIDTH  forwarded rt value, used for stores.
- `ex_rd`  out  RA  destination register.
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg`  out  1 each  control bits.
- `load_use_stall`  out  1  tells PC/IF/ID to hold.

## Operation
- **Registered fields:** valid, rs/rt data, imm, shamt, rs, rt, rd, alu_control, alu_src, and the four control bits.
- **Bubble:** every field is 0. Control bits 0, alu_control 6'b000000 (SLL of 0), so the ALU result is 0 and nothing is written.
- **Update priority at each edge:**
  1. `rst`: bubble.
  2. `flush`: bubble. Flush wins over stall.
  3. `stall`: hold every field.
  4. `load_use_stall`: bubble.
  5. Otherwise load the ID fields. If `id_valid`=0, load a bubble instead.
- **Load-use hazard:** `load_use_stall` = `ex_valid` & `ex_mem_read` & (`ex_rd`≠0) & `id_valid` & (`ex_rd`==`id_rs` | `ex_rd`==`id_rt`). It is combinational. The rt compare is conservative.
- **Forwarding,** computed separately for rs and rt:
  - Use `exmem_result` if `exmem_reg_write` & `exmem_rd`≠0 & `exmem_rd`==reg.
  - Otherwise use `memwb_result` under the same conditions with `memwb_*`.
  - Otherwise use the registered data.
  - EX/MEM has priority over MEM/WB.
  - Register 0 is never forwarded.
- **Operand build:**
  - Shift codes are 6'b000000, 6'b000010 and 6'b000011. For these, `ex_a` = fwd_rt and `ex_b` = {27'b0, shamt}.
  - For all other codes, `ex_a` = fwd_rs and `ex_b` = `alu_src` ? imm : fwd_rt.
- `ex_store_data` = fwd_rt.
- `ex_alu_control` passes the registered code through unchanged. Decode output is not checked.

## Timing
- Latency: an instruction accepted at edge N drives `ex_*` from edge N until the next update.
- `ex_a`, `ex_b` and `ex_store_data` are combinational from the registered state plus the forwarding inputs. They settle in the same cycle.
- Reset: every output is 0 one edge after `rst`=1, except `load_use_stall`, which is 0 because `ex_valid`=0.
- `rst` mid-stall or mid-hazard: bubble at that edge; the pending instruction is lost.
- Bubble on a hazard: exactly one cycle. The hazard clears the next cycle because `ex_valid`=0.
- Under `stall`, `load_use_stall` may stay asserted. It has no effect on the held state.
- `stall` and `flush` asserted together: bubble.

## Structure
- **Shared package/header `alu_defs`:** the ALU function codes (ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SLT 101010, SLL 000000, SRL 000010, SRA 000011) and the shift-detect function. The `alu` uses the same header.
- **Operand selection:** reuses the existing `mux` (WIDTH=32) for `ex_a` and the `alu_src` select.
- **Sub-module `fwd_unit`:** one reg/data in, one forwarded value out. Instantiated twice, for rs and rt.

## Test plan
- **Reset:** `rst`=1 for 2 cycles with arbitrary ID inputs → all outputs 0, `ex_valid`=0.
- **Plain ADD:** rs_data=1, rt_data=2, alu_src=0, code 100000, no forwarding → next cycle `ex_a`=1, `ex_b`=2; `alu` result 3.
- **Shift:** SRA with rt_data=32'h80000004, shamt=2 → `ex_a`=80000004, `ex_b`=2; `alu` result E0000001.
- **Forward priority:** ex rs=5, `exmem_rd`=5 with result AAAA, `memwb_rd`=5 with result BBBB → `ex_a`=AAAA. With `exmem_rd`=0, or `exmem_rd`=5 and `exmem_reg_write`=0 → `ex_a`=BBBB. With rs=0 → registered data.
- **Load-use:** lw to r8 in EX, ID instruction reads r8 → `load_use_stall`=1 for one cycle, one bubble, then the dependent instruction loads.
- **Stall/flush:** `stall`=1 for 3 cycles → `ex_*` unchanged. `stall`=`flush`=1 → bubble. Release with `id_valid`=0 → bubble.

Source files
------------

// File: rtl/alu_defs.sv
// ALU function codes and helpers. This file is shared by the ALU and the
// ID/EX operand stage.
package alu_defs;

    localparam int SHAMT_W    = 5;
    localparam int ALU_CTRL_W = 6;

    typedef enum logic [ALU_CTRL_W-1:0] {
        ALU_SLL = 6'b000000,
        ALU_SRL = 6'b000010,
        ALU_SRA = 6'b000011,
        ALU_ADD = 6'b100000,
        ALU_SUB = 6'b100010,
        ALU_AND = 6'b100100,
        ALU_OR  = 6'b100101,
        ALU_XOR = 6'b100110,
        ALU_NOR = 6'b100111,
        ALU_SLT = 6'b101010
    } alu_op_e;

    // Shift operations shift rt by shamt, so they swap the operand routing.
    function automatic logic is_shift(input logic [ALU_CTRL_W-1:0] code);
        return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
    endfunction

endpackage

// File: rtl/ex_operand_stage_fwd_unit.sv
// Forwarding for one source register: EX/MEM first, then MEM/WB, then the
// value read from the register file. Register 0 is never forwarded.
module fwd_unit #(
    parameter int WIDTH = 32,
    parameter int RA    = 5
) (
    input  logic [RA-1:0]    i_reg,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_exmem_reg_write,
    input  logic [RA-1:0]    i_exmem_rd,
    input  logic [WIDTH-1:0] i_exmem_result,
    input  logic             i_memwb_reg_write,
    input  logic [RA-1:0]    i_memwb_rd,
    input  logic [WIDTH-1:0] i_memwb_result,
    output logic [WIDTH-1:0] o_data
);

    logic w_hit_exmem;
    logic w_hit_memwb;

    assign w_hit_exmem = i_exmem_reg_write && (i_exmem_rd != '0) && (i_exmem_rd == i_reg);
    assign w_hit_memwb = i_memwb_reg_write && (i_memwb_rd != '0) && (i_memwb_rd == i_reg);

    // The youngest producer (EX/MEM) wins over the older one (MEM/WB).
    always_comb begin
        if (w_hit_exmem) begin
            o_data = i_exmem_result;
        end else if (w_hit_memwb) begin
            o_data = i_memwb_result;
        end else begin
            o_data = i_data;
        end
    end

endmodule

// File: rtl/mux.sv
// Generic two-input multiplexer used for operand selection.
module mux #(
    parameter int WIDTH = 32
) (
    input  logic             i_sel,
    input  logic [WIDTH-1:0] i_d0,
    input  logic [WIDTH-1:0] i_d1,
    output logic [WIDTH-1:0] o_y
);

    // Select d1 when i_sel is high, otherwise d0.
    always_comb begin
        o_y = i_sel ? i_d1 : i_d0;
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with forwarding, ALU operand build and load-use
// hazard detection. A hazard inserts a single bubble by itself.
module ex_operand_stage
    import alu_defs::*;
#(
    parameter int WIDTH = 32,
    parameter int RA    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [WIDTH-1:0] id_rs_data,
    input  logic [WIDTH-1:0] id_rt_data,
    input  logic [WIDTH-1:0] id_imm,
    input  logic [4:0]       id_shamt,
    input  logic [RA-1:0]    id_rs,
    input  logic [RA-1:0]    id_rt,
    input  logic [RA-1:0]    id_rd,
    input  logic [5:0]       id_alu_control,
    input  logic             id_alu_src,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_mem_to_reg,
    input  logic             stall,
    input  logic             flush,
    input  logic             exmem_reg_write,
    input  logic [RA-1:0]    exmem_rd,
    input  logic [WIDTH-1:0] exmem_result,
    input  logic             memwb_reg_write,
    input  logic [RA-1:0]    memwb_rd,
    input  logic [WIDTH-1:0] memwb_result,
    output logic             ex_valid,
    output logic [WIDTH-1:0] ex_a,
    output logic [WIDTH-1:0] ex_b,
    output logic [5:0]       ex_alu_control,
    output logic [WIDTH-1:0] ex_store_data,
    output logic [RA-1:0]    ex_rd,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_mem_to_reg,
    output logic             load_use_stall
);

    // Registered instruction fields
    logic             r_valid;
    logic [WIDTH-1:0] r_rs_data;
    logic [WIDTH-1:0] r_rt_data;
    logic [WIDTH-1:0] r_imm;
    logic [4:0]       r_shamt;
    logic [RA-1:0]    r_rs;
    logic [RA-1:0]    r_rt;
    logic [RA-1:0]    r_rd;
    logic [5:0]       r_alu_control;
    logic             r_alu_src;
    logic             r_reg_write;
    logic             r_mem_read;
    logic             r_mem_write;
    logic             r_mem_to_reg;

    logic             w_load_use;
    logic             w_bubble;
    logic             w_load;
    logic [WIDTH-1:0] w_fwd_rs;
    logic [WIDTH-1:0] w_fwd_rt;
    logic [WIDTH-1:0] w_b_reg_imm;
    logic [WIDTH-1:0] w_shamt_ext;
    logic             w_is_shift;

    // A load in EX whose target is read by the instruction in ID cannot be
    // forwarded in time; the rt compare is conservative (stores, immediates).
    assign w_load_use = r_valid && r_mem_read && (r_rd != '0) && id_valid &&
                        ((r_rd == id_rs) || (r_rd == id_rt));

    // Flush beats stall; stall beats the hazard bubble; an empty ID slot
    // becomes a bubble as well.
    assign w_bubble = rst || flush || (!stall && (w_load_use || !id_valid));
    assign w_load   = !w_bubble && !stall;

    // Pipeline register: bubble clears every field, stall holds them all.
    always_ff @(posedge clk) begin
        if (w_bubble) begin
            r_valid       <= 1'b0;
            r_rs_data     <= '0;
            r_rt_data     <= '0;
            r_imm         <= '0;
            r_shamt       <= '0;
            r_rs          <= '0;
            r_rt          <= '0;
            r_rd          <= '0;
            r_alu_control <= '0;
            r_alu_src     <= 1'b0;
            r_reg_write   <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_to_reg  <= 1'b0;
        end else if (w_load) begin
            r_valid       <= 1'b1;
            r_rs_data     <= id_rs_data;
            r_rt_data     <= id_rt_data;
            r_imm         <= id_imm;
            r_shamt       <= id_shamt;
            r_rs          <= id_rs;
            r_rt          <= id_rt;
            r_rd          <= id_rd;
            r_alu_control <= id_alu_control;
            r_alu_src     <= id_alu_src;
            r_reg_write   <= id_reg_write;
            r_mem_read    <= id_mem_read;
            r_mem_write   <= id_mem_write;
            r_mem_to_reg  <= id_mem_to_reg;
        end
    end

    fwd_unit #(.WIDTH(WIDTH), .RA(RA)) u_fwd_rs (
        .i_reg             (r_rs),
        .i_data            (r_rs_data),
        .i_exmem_reg_write (exmem_reg_write),
        .i_exmem_rd        (exmem_rd),
        .i_exmem_result    (exmem_result),
        .i_memwb_reg_write (memwb_reg_write),
        .i_memwb_rd        (memwb_rd),
        .i_memwb_result    (memwb_result),
        .o_data            (w_fwd_rs)
    );

    fwd_unit #(.WIDTH(WIDTH), .RA(RA)) u_fwd_rt (
        .i_reg             (r_rt),
        .i_data            (r_rt_data),
        .i_exmem_reg_write (exmem_reg_write),
        .i_exmem_rd        (exmem_rd),
        .i_exmem_result    (exmem_result),
        .i_memwb_reg_write (memwb_reg_write),
        .i_memwb_rd        (memwb_rd),
        .i_memwb_result    (memwb_result),
        .o_data            (w_fwd_rt)
    );

    assign w_is_shift  = is_shift(r_alu_control);
    assign w_shamt_ext = {{(WIDTH-SHAMT_W){1'b0}}, r_shamt};

    // Shifts operate on rt; everything else takes rs as the first operand.
    mux #(.WIDTH(WIDTH)) u_mux_a (
        .i_sel (w_is_shift),
        .i_d0  (w_fwd_rs),
        .i_d1  (w_fwd_rt),
        .o_y   (ex_a)
    );

    mux #(.WIDTH(WIDTH)) u_mux_alu_src (
        .i_sel (r_alu_src),
        .i_d0  (w_fwd_rt),
        .i_d1  (r_imm),
        .o_y   (w_b_reg_imm)
    );

    mux #(.WIDTH(WIDTH)) u_mux_b (
        .i_sel (w_is_shift),
        .i_d0  (w_b_reg_imm),
        .i_d1  (w_shamt_ext),
        .o_y   (ex_b)
    );

    assign ex_valid       = r_valid;
    assign ex_alu_control = r_alu_control;
    assign ex_store_data  = w_fwd_rt;
    assign ex_rd          = r_rd;
    assign ex_reg_write   = r_reg_write;
    assign ex_mem_read    = r_mem_read;
    assign ex_mem_write   = r_mem_write;
    assign ex_mem_to_reg  = r_mem_to_reg;
    assign load_use_stall = w_load_use;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed and randomized bench for ex_operand_stage against an
// instruction-level reference model.
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_shamt, id_rs, id_rt, id_rd;
    logic [5:0]  id_alu_control;
    logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        stall, flush;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic        ex_valid;
    logic [31:0] ex_a, ex_b, ex_store_data;
    logic [5:0]  ex_alu_control;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic        load_use_stall;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ex_operand_stage #(.WIDTH(32), .RA(5)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_shamt(id_shamt), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_alu_control(id_alu_control), .id_alu_src(id_alu_src),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .stall(stall), .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_alu_control(ex_alu_control),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .load_use_stall(load_use_stall)
    );

    // Reference model: the instruction currently sitting in EX.
    typedef struct packed {
        logic        valid;
        logic [31:0] rs_data, rt_data, imm;
        logic [4:0]  shamt, rs, rt, rd;
        logic [5:0]  code;
        logic        alu_src, rw, mr, mw, m2r;
    } instr_t;

    instr_t m;

    function automatic instr_t from_id();
        instr_t t;
        t.valid = 1'b1;
        t.rs_data = id_rs_data; t.rt_data = id_rt_data; t.imm = id_imm;
        t.shamt = id_shamt; t.rs = id_rs; t.rt = id_rt; t.rd = id_rd;
        t.code = id_alu_control; t.alu_src = id_alu_src;
        t.rw = id_reg_write; t.mr = id_mem_read; t.mw = id_mem_write; t.m2r = id_mem_to_reg;
        return t;
    endfunction

    function automatic logic model_lus();
        return m.valid && m.mr && (m.rd != 0) && id_valid && ((m.rd == id_rs) || (m.rd == id_rt));
    endfunction

    function automatic logic [31:0] model_fwd(input logic [4:0] r, input logic [31:0] d);
        if (r == 0) return d;
        if (exmem_reg_write && exmem_rd == r) return exmem_result;
        if (memwb_reg_write && memwb_rd == r) return memwb_result;
        return d;
    endfunction

    // Next EX content after a clock edge, from the current inputs.
    function automatic instr_t model_next();
        if (rst || flush) return '0;
        if (stall) return m;
        if (model_lus()) return '0;
        if (!id_valid) return '0;
        return from_id();
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string pfx);
        logic [31:0] frs, frt, ea, eb;
        logic        sh;
        frs = model_fwd(m.rs, m.rs_data);
        frt = model_fwd(m.rt, m.rt_data);
        sh  = (m.code == 6'd0) || (m.code == 6'd2) || (m.code == 6'd3);
        ea  = sh ? frt : frs;
        eb  = sh ? {27'd0, m.shamt} : (m.alu_src ? m.imm : frt);
        chk({pfx, ".valid"}, {31'd0, ex_valid}, {31'd0, m.valid});
        chk({pfx, ".a"}, ex_a, ea);
        chk({pfx, ".b"}, ex_b, eb);
        chk({pfx, ".ctl"}, {26'd0, ex_alu_control}, {26'd0, m.code});
        chk({pfx, ".store"}, ex_store_data, frt);
        chk({pfx, ".rd"}, {27'd0, ex_rd}, {27'd0, m.rd});
        chk({pfx, ".ctrl4"}, {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg},
            {28'd0, m.rw, m.mr, m.mw, m.m2r});
        chk({pfx, ".lus"}, {31'd0, load_use_stall}, {31'd0, model_lus()});
    endtask

    // One clock edge: advance the model and compare afterwards.
    task automatic step(input string pfx);
        instr_t nxt;
        nxt = model_next();
        @(posedge clk);
        m = nxt;
        #1;
        check_all(pfx);
    endtask

    task automatic idle_inputs();
        rst = 0; stall = 0; flush = 0;
        id_valid = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_shamt = 0;
        id_rs = 0; id_rt = 0; id_rd = 0; id_alu_control = 0; id_alu_src = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    task automatic set_instr(input logic [5:0] code, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                             input logic [31:0] imm, input logic [4:0] sh, input logic asrc,
                             input logic mr);
        id_valid = 1; id_alu_control = code; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_shamt = sh;
        id_alu_src = asrc; id_reg_write = 1; id_mem_read = mr; id_mem_write = 0;
        id_mem_to_reg = mr;
    endtask

    logic [5:0] codes [10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h03};

    initial begin
        m = '0;
        idle_inputs();

        // Reset with arbitrary ID inputs
        rst = 1;
        set_instr(6'h20, 5'd3, 5'd4, 5'd7, 32'hDEAD, 32'hBEEF, 32'h55, 5'd9, 1'b0, 1'b1);
        exmem_reg_write = 1; exmem_rd = 5'd3; exmem_result = 32'h1234;
        step("rst0");
        step("rst1");
        chk("rst.valid", {31'd0, ex_valid}, 32'd0);
        chk("rst.rd", {27'd0, ex_rd}, 32'd0);
        chk("rst.a", ex_a, 32'd0);
        chk("rst.b", ex_b, 32'd0);
        idle_inputs();

        // Plain ADD
        set_instr(6'h20, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd0, 5'd0, 1'b0, 1'b0);
        step("add");
        chk("add.a", ex_a, 32'd1);
        chk("add.b", ex_b, 32'd2);
        chk("add.sum", ex_a + ex_b, 32'd3);

        // SRA: operands are rt and shamt
        set_instr(6'h03, 5'd1, 5'd2, 5'd3, 32'h11, 32'h80000004, 32'h0, 5'd2, 1'b0, 1'b0);
        step("sra");
        chk("sra.a", ex_a, 32'h80000004);
        chk("sra.b", ex_b, 32'd2);

        // Forward priority on rs
        set_instr(6'h20, 5'd5, 5'd6, 5'd10, 32'h1111, 32'h2222, 32'h0, 5'd0, 1'b0, 1'b0);
        step("fwd_load");
        exmem_reg_write = 1; exmem_rd = 5'd5; exmem_result = 32'hAAAA;
        memwb_reg_write = 1; memwb_rd = 5'd5; memwb_result = 32'hBBBB;
        #1; check_all("fwd_both");
        chk("fwd_both.a", ex_a, 32'hAAAA);
        exmem_rd = 5'd0;
        #1; chk("fwd_exrd0.a", ex_a, 32'hBBBB);
        exmem_rd = 5'd5; exmem_reg_write = 0;
        #1; chk("fwd_exnowr.a", ex_a, 32'hBBBB);
        set_instr(6'h20, 5'd0, 5'd6, 5'd10, 32'h1234, 32'h2222, 32'h0, 5'd0, 1'b0, 1'b0);
        exmem_reg_write = 1; exmem_rd = 5'd0; memwb_rd = 5'd0;
        step("fwd_r0");
        chk("fwd_r0.a", ex_a, 32'h1234);
        idle_inputs();

        // Load-use: lw r8 then a reader of r8
        set_instr(6'h20, 5'd1, 5'd0, 5'd8, 32'h100, 32'h0, 32'h4, 5'd0, 1'b1, 1'b1);
        step("lw");
        set_instr(6'h20, 5'd8, 5'd2, 5'd9, 32'h7, 32'h8, 32'h0, 5'd0, 1'b0, 1'b0);
        #1; chk("lu.stall", {31'd0, load_use_stall}, 32'd1);
        step("lu_bubble");
        chk("lu.bubble", {31'd0, ex_valid}, 32'd0);
        chk("lu.clear", {31'd0, load_use_stall}, 32'd0);
        step("lu_dep");
        chk("lu.dep_rd", {27'd0, ex_rd}, 32'd9);

        // Stall holds for three cycles while ID changes
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            set_instr(6'h22, 5'(i + 11), 5'd12, 5'd13, $urandom, $urandom, $urandom, 5'd1, 1'b1, 1'b0);
            step("stall");
            chk("stall.rd", {27'd0, ex_rd}, 32'd9);
        end
        flush = 1;
        step("stall_flush");
        chk("sf.valid", {31'd0, ex_valid}, 32'd0);
        stall = 0; flush = 0; id_valid = 0;
        step("release_idle");
        chk("rel.valid", {31'd0, ex_valid}, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            rst   = ($urandom_range(0, 49) == 0);
            flush = ($urandom_range(0, 19) == 0);
            stall = ($urandom_range(0, 6) == 0);
            id_valid = ($urandom_range(0, 4) != 0);
            id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
            id_shamt = 5'($urandom); id_rs = 5'($urandom_range(0, 7));
            id_rt = 5'($urandom_range(0, 7)); id_rd = 5'($urandom_range(0, 7));
            id_alu_control = ($urandom_range(0, 9) == 0) ? 6'($urandom) : codes[$urandom_range(0, 9)];
            id_alu_src = 1'($urandom); id_reg_write = 1'($urandom);
            id_mem_read = ($urandom_range(0, 2) == 0); id_mem_write = 1'($urandom);
            id_mem_to_reg = 1'($urandom);
            exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom_range(0, 7)); exmem_result = $urandom;
            memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom_range(0, 7)); memwb_result = $urandom;
            #1; chk("rnd.lus_pre", {31'd0, load_use_stall}, {31'd0, model_lus()});
            step("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
